// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared types and defaults for the multi-port register file
package reg_file_pkg;

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_t;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 3;

endpackage

// File: rtl/reg_file_clr_fsm.sv
// rtl/reg_file_clr_fsm.sv - clear sweep sequencer, one entry per cycle then a done pulse
module reg_file_clr_fsm
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  clr_state_t        state, state_nxt;
  logic [ADDR_W-1:0] clr_ptr, clr_ptr_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    clr_busy    = 1'b0;
    clr_done    = 1'b0;
    clr_we      = 1'b0;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt   = CLEAR;
          clr_ptr_nxt = '0;
        end
      end
      CLEAR: begin
        clr_busy    = 1'b1;
        clr_we      = 1'b1;
        clr_ptr_nxt = clr_ptr + 1'b1;
        // leave before the pointer wraps so no entry is swept twice
        if (clr_ptr == LAST_ADDR) state_nxt = DONE;
      end
      DONE: begin
        clr_busy  = 1'b1;
        clr_done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign clr_addr = clr_ptr;

endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - parametrised multi-read-port register file with valid bits and clear sweep
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int NUM_RD  = 2,
  parameter int ZERO_R0 = 0,
  parameter int BYPASS  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_ack,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done
);

  localparam int   DEPTH  = 1 << ADDR_W;
  localparam logic R0_HW  = (ZERO_R0 != 0);
  localparam logic BYP_ON = (BYPASS != 0);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  reg_file_clr_fsm #(.ADDR_W(ADDR_W)) u_clr (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // busy covers both CLEAR and DONE, so writes are refused for the whole sweep
  assign wr_ack = wr_en && !clr_busy && !(R0_HW && (wr_addr == '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
      valid <= {{(DEPTH-1){1'b0}}, R0_HW};
    end else if (clr_we) begin
      mem[clr_addr]   <= '0;
      valid[clr_addr] <= R0_HW && (clr_addr == '0);
    end else if (wr_ack) begin
      mem[wr_addr]   <= wr_data;
      valid[wr_addr] <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              vld;

    assign addr = rd_addr[i*ADDR_W +: ADDR_W];

    // hardwired R0 is applied last so it wins over the bypass path
    always_comb begin
      data = mem[addr];
      vld  = valid[addr];
      if (BYP_ON && wr_ack && (wr_addr == addr)) begin
        data = wr_data;
        vld  = 1'b1;
      end
      if (R0_HW && (addr == '0)) begin
        data = '0;
        vld  = 1'b1;
      end
    end

    assign rd_data[i*DATA_W +: DATA_W] = data;
    assign rd_valid[i]                 = vld;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - self-checking bench for reg_file_mp (default and R0/no-bypass variants)
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [5:0]  rd_addr = '0;
  logic        clr_req = 1'b0;

  logic        ack_a, busy_a, done_a, ack_b, busy_b, done_b;
  logic [31:0] rdd_a, rdd_b;
  logic [1:0]  rdv_a, rdv_b;

  int n_vec = 0;
  int n_bad = 0;

  // instance A: defaults (no hardwired R0, bypass on); instance B: hardwired R0, bypass off
  reg_file_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2), .ZERO_R0(0), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(ack_a),
    .rd_addr(rd_addr), .rd_data(rdd_a), .rd_valid(rdv_a),
    .clr_req(clr_req), .clr_busy(busy_a), .clr_done(done_a));

  reg_file_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2), .ZERO_R0(1), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(ack_b),
    .rd_addr(rd_addr), .rd_data(rdd_b), .rd_valid(rdv_b),
    .clr_req(clr_req), .clr_busy(busy_b), .clr_done(done_b));

  always #5 clk = ~clk;

  // reference contents per instance plus sweep progress: 0 idle, 1..8 clearing entry n-1, 9 done
  logic [15:0] m_mem [2][8];
  logic        m_val [2][8];
  int          sweep;

  function automatic logic zr(int k);
    return k == 1;
  endfunction

  function automatic logic byp(int k);
    return k == 0;
  endfunction

  function automatic logic exp_ack(int k);
    return wr_en && (sweep == 0) && !(zr(k) && wr_addr == 3'd0);
  endfunction

  function automatic logic [15:0] exp_data(int k, logic [2:0] a);
    if (zr(k) && a == 3'd0) return 16'h0000;
    if (byp(k) && exp_ack(k) && wr_addr == a) return wr_data;
    return m_mem[k][a];
  endfunction

  function automatic logic exp_vld(int k, logic [2:0] a);
    if (zr(k) && a == 3'd0) return 1'b1;
    if (byp(k) && exp_ack(k) && wr_addr == a) return 1'b1;
    return m_val[k][a];
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++)
        for (int e = 0; e < 8; e++) begin
          m_mem[k][e] <= 16'h0000;
          m_val[k][e] <= zr(k) && e == 0;
        end
      sweep <= 0;
    end else if (sweep == 0) begin
      for (int k = 0; k < 2; k++)
        if (exp_ack(k)) begin
          m_mem[k][wr_addr] <= wr_data;
          m_val[k][wr_addr] <= 1'b1;
        end
      if (clr_req) sweep <= 1;
    end else if (sweep <= 8) begin
      for (int k = 0; k < 2; k++) begin
        m_mem[k][sweep-1] <= 16'h0000;
        m_val[k][sweep-1] <= zr(k) && sweep == 1;
      end
      sweep <= sweep + 1;
    end else begin
      sweep <= 0;
    end
  end

  always @(negedge clk) begin
    logic [31:0] dd;
    logic [1:0]  vv;
    logic        ak, bz, dn;
    for (int k = 0; k < 2; k++) begin
      dd = (k == 0) ? rdd_a : rdd_b;
      vv = (k == 0) ? rdv_a : rdv_b;
      ak = (k == 0) ? ack_a : ack_b;
      bz = (k == 0) ? busy_a : busy_b;
      dn = (k == 0) ? done_a : done_b;
      chk($sformatf("cyc_ack[%0d]", k), {31'b0, ak}, {31'b0, exp_ack(k)});
      chk($sformatf("cyc_busy[%0d]", k), {31'b0, bz}, {31'b0, sweep != 0});
      chk($sformatf("cyc_done[%0d]", k), {31'b0, dn}, {31'b0, sweep == 9});
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("cyc_rd_data[%0d][%0d]", k, p), {16'b0, dd[p*16 +: 16]},
            {16'b0, exp_data(k, rd_addr[p*3 +: 3])});
        chk($sformatf("cyc_rd_valid[%0d][%0d]", k, p), {31'b0, vv[p]},
            {31'b0, exp_vld(k, rd_addr[p*3 +: 3])});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int busy_cycles;
    int done_at;
    int done_seen;

    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    for (int a = 0; a < 8; a++) begin
      rd_addr = {3'(a), 3'(a)};
      #2;
      chk("reset_rd_data", {16'b0, rdd_a[15:0]}, 32'h0);
      chk("reset_rd_valid", {30'b0, rdv_a}, 32'h0);
      chk("reset_busy", {31'b0, busy_a}, 32'h0);
      tick();
    end

    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'hBEEF;
    tick();
    wr_en = 1'b0; rd_addr = {3'd5, 3'd5};
    #2;
    chk("wr_rd_port0", {16'b0, rdd_a[15:0]}, 32'hBEEF);
    chk("wr_rd_port1", {16'b0, rdd_a[31:16]}, 32'hBEEF);
    chk("wr_rd_valid", {30'b0, rdv_a}, 32'h3);
    rd_addr = {3'd4, 3'd4};
    #2;
    chk("untouched_data", {16'b0, rdd_a[15:0]}, 32'h0);
    chk("untouched_valid", {30'b0, rdv_a}, 32'h0);
    tick();

    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h1234; rd_addr = {3'd5, 3'd3};
    #2;
    chk("bypass_on", {16'b0, rdd_a[15:0]}, 32'h1234);
    chk("bypass_off", {16'b0, rdd_b[15:0]}, 32'h0);
    tick();

    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF; rd_addr = {3'd5, 3'd0};
    #2;
    chk("r0_wr_ack", {31'b0, ack_b}, 32'h0);
    chk("r0_rd_data", {16'b0, rdd_b[15:0]}, 32'h0);
    chk("r0_rd_valid", {31'b0, rdv_b[0]}, 32'h1);
    chk("nr0_wr_ack", {31'b0, ack_a}, 32'h1);
    tick();

    for (int a = 0; a < 8; a++) begin
      wr_en = 1'b1; wr_addr = 3'(a); wr_data = 16'hA5A5;
      tick();
    end
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h7777; clr_req = 1'b1;
    #2;
    chk("wr_with_clr_ack", {31'b0, ack_a}, 32'h1);
    tick();

    busy_cycles = 0;
    done_at = 0;
    for (int c = 1; c <= 20; c++) begin
      wr_en = (c == 3); wr_addr = 3'd6; wr_data = 16'h5555; clr_req = (c == 4);
      rd_addr = {3'(c), 3'(c - 1)};
      #2;
      if (c == 3) chk("wr_ack_in_sweep", {31'b0, ack_a}, 32'h0);
      if (!busy_a) break;
      busy_cycles++;
      if (done_a) done_at = c;
      tick();
    end
    wr_en = 1'b0; clr_req = 1'b0;
    chk("sweep_busy_cycles", busy_cycles, 9);
    chk("sweep_done_cycle", done_at, 9);
    for (int a = 0; a < 8; a++) begin
      rd_addr = {3'(a), 3'(a)};
      #2;
      chk("cleared_data", {16'b0, rdd_a[15:0]}, 32'h0);
      chk("cleared_valid", {30'b0, rdv_a}, 32'h0);
      tick();
    end

    wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'h1111;
    tick();
    wr_en = 1'b0; clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (3) tick();
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_busy", {31'b0, busy_a}, 32'h0);
    chk("rst_mid_done", {31'b0, done_a}, 32'h0);
    tick();
    rst = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 12; c++) begin
      #2;
      if (done_a || busy_a) done_seen++;
      tick();
    end
    chk("no_done_after_rst", done_seen, 0);

    wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'hC0DE; rd_addr = {3'd7, 3'd6};
    #2;
    chk("post_rst_ack", {31'b0, ack_a}, 32'h1);
    tick();
    wr_en = 1'b0;
    #2;
    chk("post_rst_data", {16'b0, rdd_a[31:16]}, 32'hC0DE);
    chk("post_rst_valid", {30'b0, rdv_a}, 32'h2);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
